// File: rtl/run_detect.sv
// ============================================================================
//  Module      : run_detect
//  Description : Serial run detector. Flags K consecutive qualified samples
//                equal to a programmable bit, overlapping or not.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module run_detect #(
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter int RST_LEN = 3,
    parameter bit RST_VAL = 1'b1,
    parameter bit RST_OVL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_ld,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_val,
    input  logic             cfg_ovl,
    input  logic             clr,
    input  logic             vld,
    input  logic             i,
    output logic             y,
    output logic             y_q,
    output logic [LEN_W-1:0] run,
    output logic [CNT_W-1:0] det_cnt
);

    localparam logic [LEN_W-1:0] C_RUN_MAX = {LEN_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0] C_RST_LEN = LEN_W'(RST_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_t;

    state_t           r_state, w_state_d;
    logic [LEN_W-1:0] r_len, r_run, w_run_d, w_keff;
    logic [LEN_W:0]   w_run_nxt;
    logic             r_val, r_ovl, w_hit, r_y;
    logic [CNT_W-1:0] r_cnt;

    assign w_keff    = (r_len == '0) ? LEN_W'(1) : r_len;
    assign w_run_nxt = {1'b0, r_run} + 1'b1;

    always_comb begin
        w_state_d = r_state;
        w_run_d   = r_run;
        w_hit     = 1'b0;
        if (clr || cfg_ld) begin
            w_state_d = IDLE;
            w_run_d   = '0;
        end else if (vld) begin
            if (i != r_val) begin
                w_state_d = IDLE;
                w_run_d   = '0;
            end else begin
                case (r_state)
                    HIT: begin
                        w_hit = 1'b1;
                        if (r_run != C_RUN_MAX) begin
                            w_run_d = r_run + 1'b1;
                        end
                    end
                    default: begin
                        // In IDLE/RUN the run is below Keff, so the increment cannot overflow
                        if (w_run_nxt < {1'b0, w_keff}) begin
                            w_state_d = RUN;
                            w_run_d   = w_run_nxt[LEN_W-1:0];
                        end else begin
                            w_hit = 1'b1;
                            if (r_ovl) begin
                                w_state_d = HIT;
                                w_run_d   = w_run_nxt[LEN_W-1:0];
                            end else begin
                                w_state_d = IDLE;
                                w_run_d   = '0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Gate with reset so the Mealy output is quiet while reset is held
    assign y = w_hit & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_run   <= '0;
            r_y     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_run   <= w_run_d;
            r_y     <= y;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len <= C_RST_LEN;
            r_val <= RST_VAL;
            r_ovl <= RST_OVL;
        end else if (cfg_ld) begin
            r_len <= cfg_len;
            r_val <= cfg_val;
            r_ovl <= cfg_ovl;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (y && (r_cnt != C_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign y_q     = r_y;
    assign run     = r_run;
    assign det_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_run_detect.sv
// ============================================================================
//  Module      : tb_run_detect
//  Description : Self-checking bench for run_detect (default and narrow builds).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_run_detect;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_ld = 1'b0, cfg_val = 1'b0, cfg_ovl = 1'b0;
    logic [3:0] cfg_len = 4'd0;
    logic       clr = 1'b0, vld = 1'b0, i = 1'b0;

    logic       y_a, yq_a, y_b, yq_b;
    logic [3:0] run_a;
    logic [7:0] cnt_a;
    logic [1:0] run_b, cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    run_detect #(.LEN_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .cfg_ld(cfg_ld), .cfg_len(cfg_len), .cfg_val(cfg_val),
        .cfg_ovl(cfg_ovl), .clr(clr), .vld(vld), .i(i),
        .y(y_a), .y_q(yq_a), .run(run_a), .det_cnt(cnt_a)
    );

    run_detect #(.LEN_W(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .cfg_ld(cfg_ld), .cfg_len(cfg_len[1:0]), .cfg_val(cfg_val),
        .cfg_ovl(cfg_ovl), .clr(clr), .vld(vld), .i(i),
        .y(y_b), .y_q(yq_b), .run(run_b), .det_cnt(cnt_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an unbounded streak counter and detection tally per build
    int m_run[2], m_cnt[2], m_len[2], m_val[2], m_ovl[2], m_yq[2];
    int maxr[2] = '{15, 3};
    int maxc[2] = '{255, 3};

    function automatic int keff(input int k);
        return (m_len[k] == 0) ? 1 : m_len[k];
    endfunction

    function automatic int model_y(input int k);
        return (!clr && !cfg_ld && vld && (int'(i) == m_val[k]) && (m_run[k] + 1 >= keff(k))) ? 1 : 0;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_cnt[k] = 0; m_yq[k] = 0;
            m_len[k] = 3; m_val[k] = 1; m_ovl[k] = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) begin
                model_reset();
                chk("rst y_a", int'(y_a), 0);     chk("rst y_b", int'(y_b), 0);
                chk("rst run_a", int'(run_a), 0); chk("rst cnt_a", int'(cnt_a), 0);
                chk("rst yq_b", int'(yq_b), 0);   chk("rst cnt_b", int'(cnt_b), 0);
            end else begin
                chk("y_a", int'(y_a), model_y(0));
                chk("yq_a", int'(yq_a), m_yq[0]);
                chk("run_a", int'(run_a), min2(m_run[0], maxr[0]));
                chk("cnt_a", int'(cnt_a), min2(m_cnt[0], maxc[0]));
                chk("y_b", int'(y_b), model_y(1));
                chk("yq_b", int'(yq_b), m_yq[1]);
                chk("run_b", int'(run_b), min2(m_run[1], maxr[1]));
                chk("cnt_b", int'(cnt_b), min2(m_cnt[1], maxc[1]));
            end
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < 2; k++) begin
                    int ey;
                    ey = model_y(k);
                    m_yq[k] = ey;
                    if (clr || cfg_ld) begin
                        m_run[k] = 0;
                        if (clr) m_cnt[k] = 0;
                        if (cfg_ld) begin
                            m_len[k] = (k == 0) ? int'(cfg_len) : int'(cfg_len[1:0]);
                            m_val[k] = int'(cfg_val);
                            m_ovl[k] = int'(cfg_ovl);
                        end
                    end else if (vld) begin
                        if (int'(i) == m_val[k]) begin
                            m_run[k]++;
                            if (m_ovl[k] == 0 && m_run[k] >= keff(k)) m_run[k] = 0;
                        end else begin
                            m_run[k] = 0;
                        end
                    end
                    if (ey != 0) m_cnt[k]++;
                end
            end
        end
    end

    task automatic step(input bit v, input bit b, input bit c, input bit ld, output bit ya);
        vld = v; i = b; clr = c; cfg_ld = ld;
        #2;
        ya = y_a;
        @(posedge clk);
        #1;
        clr = 1'b0; cfg_ld = 1'b0;
    endtask

    task automatic seq(input string name, input int n, input logic [15:0] vm,
                       input logic [15:0] bits, input logic [15:0] ey);
        bit ya;
        for (int s = 0; s < n; s++) begin
            step(vm[s], bits[s], 1'b0, 1'b0, ya);
            if (vm[s]) begin
                chk($sformatf("%s y[%0d]", name, s), int'(ya), int'(ey[s]));
                chk($sformatf("%s y_q[%0d]", name, s), int'(yq_a), int'(ey[s]));
            end
        end
        vld = 1'b0;
    endtask

    task automatic load(input int len, input bit val, input bit ovl, input bit c);
        bit ya;
        cfg_len = 4'(len); cfg_val = val; cfg_ovl = ovl;
        step(1'b1, val, c, 1'b1, ya);
        chk("cfg_ld y", int'(ya), 0);
        cfg_len = 4'd0; cfg_val = ~val; cfg_ovl = ~ovl;
        vld = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ya;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("post-reset run_a", int'(run_a), 0);
        chk("post-reset cnt_a", int'(cnt_a), 0);

        seq("t1", 9, 16'h01FF, 16'b111011110, 16'b100011000);
        chk("t1 det_cnt", int'(cnt_a), 3);

        load(3, 1'b1, 1'b0, 1'b1);
        seq("t2", 7, 16'h007F, 16'b1111111, 16'b0100100);
        chk("t2 run", int'(run_a), 1);
        chk("t2 det_cnt", int'(cnt_a), 2);

        load(2, 1'b0, 1'b1, 1'b1);
        seq("t3", 7, 16'b1111011, 16'b0010000, 16'b1001010);
        chk("t3 det_cnt", int'(cnt_a), 3);

        load(0, 1'b1, 1'b0, 1'b1);
        seq("t4", 3, 16'h0007, 16'b101, 16'b101);
        chk("t4 run", int'(run_a), 0);
        chk("t4 det_cnt", int'(cnt_a), 2);

        load(3, 1'b1, 1'b1, 1'b1);
        seq("t5", 6, 16'h003F, 16'b110111, 16'b000100);
        chk("t5 run", int'(run_a), 2);
        cfg_len = 4'd3; cfg_val = 1'b1; cfg_ovl = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1, ya);
        chk("t5 cfg_ld y", int'(ya), 0);
        chk("t5 cfg_ld run", int'(run_a), 0);
        chk("t5 cfg_ld cnt", int'(cnt_a), 1);
        seq("t5b", 2, 16'h0003, 16'b11, 16'b00);
        step(1'b1, 1'b1, 1'b1, 1'b0, ya);
        chk("t5 clr y", int'(ya), 0);
        chk("t5 clr run", int'(run_a), 0);
        chk("t5 clr cnt", int'(cnt_a), 0);

        load(2, 1'b0, 1'b1, 1'b0);
        seq("t5c", 2, 16'h0003, 16'b00, 16'b10);
        chk("t5c cnt", int'(cnt_a), 1);
        #2 rst = 1'b0;
        #1;
        chk("async y", int'(y_a), 0);
        chk("async y_q", int'(yq_a), 0);
        chk("async run", int'(run_a), 0);
        chk("async cnt", int'(cnt_a), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        seq("t5d", 4, 16'h000F, 16'b1110, 16'b1000);

        step(1'b0, 1'b0, 1'b1, 1'b0, ya);
        seq("t6", 12, 16'h0FFF, 16'hFFF, 16'b111111111100);
        chk("t6 run_b", int'(run_b), 3);
        chk("t6 cnt_b", int'(cnt_b), 3);
        chk("t6 run_a", int'(run_a), 12);
        chk("t6 cnt_a", int'(cnt_a), 10);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/run_detect.md
Name: run_detect

Overview:
- Parametrised serial run detector: flags when a programmable number K of consecutive qualified samples equal a programmable bit value (0 or 1).
- Overlapping and non-overlapping detection modes.
- Provides a Mealy detect flag, a registered copy of it, the live run length and a saturating detection counter.
- Sits on a serial bitstream next to protocol/framing logic; the default configuration detects three consecutive 1s with overlap.

Parameters:
- LEN_W, 4, width of the run-length config and run counter; maximum K = 2^LEN_W-1.
- CNT_W, 8, width of the detection counter.
- RST_LEN, 3, K loaded at reset; must be 1..2^LEN_W-1.
- RST_VAL, 1, match bit value loaded at reset.
- RST_OVL, 1, overlap mode loaded at reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- cfg_ld  in  1  synchronous pulse: load cfg_len/cfg_val/cfg_ovl.
- cfg_len  in  LEN_W  run length K; 0 is treated as 1.
- cfg_val  in  1  bit value to match.
- cfg_ovl  in  1  1 = overlapping, 0 = non-overlapping.
- clr  in  1  synchronous clear of the FSM, run and det_cnt.
- vld  in  1  sample qualifier for i.
- i  in  1  serial data bit.
- y  out  1  combinational detect, asserted in the cycle the K-th matching bit is presented.
- y_q  out  1  y registered (one cycle later).
- run  out  LEN_W  current consecutive-match count, saturating at 2^LEN_W-1.
- det_cnt  out  CNT_W  detections since reset/clr, saturating at 2^CNT_W-1.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, run=0, det_cnt=0, y_q=0.
  - Config registers load RST_LEN/RST_VAL/RST_OVL.
  - y=0 while in reset.
- Effective length: Keff = (len_reg==0) ? 1 : len_reg.
- Match: m = vld && (i==val_reg).
- FSM states:
  - IDLE: run==0.
  - RUN: 0<run<Keff.
  - HIT: overlap mode only, run>=Keff.
- vld=0: state, run and det_cnt hold; y=0.
- vld=1 && i!=val_reg (any state): next state=IDLE, run=0, y=0.
- m=1 in IDLE/RUN, with nxt = run+1:
  - nxt<Keff: state=RUN, run=nxt, y=0.
  - nxt>=Keff: y=1. Overlap: state=HIT, run=nxt. Non-overlap: state=IDLE, run=0; a new detection needs Keff fresh matches.
- m=1 in HIT: y=1, stay in HIT, run=min(run+1, 2^LEN_W-1).
- y is combinational from state, run, vld, i and config (Mealy); zero latency.
- y_q <= y each cycle.
- det_cnt increments on every cycle with y=1, saturating; it never wraps.
- cfg_ld=1:
  - Config registers load at the clock edge; state->IDLE, run->0.
  - The same-cycle sample is discarded: y forced 0, det_cnt unchanged.
  - The new config applies from the next cycle.
- clr=1:
  - state->IDLE, run->0, det_cnt->0; y forced 0 that cycle.
  - Config registers are unchanged.
  - If cfg_ld is also asserted, both take effect.
- Priority: rst > clr/cfg_ld > sample processing.
- Keff=1: every match asserts y. In non-overlap mode the FSM stays in IDLE and y follows m.
- Config changes take effect only through cfg_ld; the cfg_* inputs are ignored otherwise.

Test Plan:
- Default after reset, vld=1, i=0,1,1,1,1,0,1,1,1 -> y=1 on the 4th, 5th and 9th samples; y_q one cycle later each; det_cnt=3; run=4 after the 5th sample, 0 after the 6th.
- cfg_ld len=3, val=1, ovl=0; i=1×7 -> y=1 on the 3rd and 6th samples only; run sequence 1,2,0,1,2,0,1; det_cnt=2.
- cfg_ld len=2, val=0, ovl=1; i=0,0,0,1,0,0 with vld low for one cycle between the 2nd and 3rd zeros -> y=1 on the 2nd, 3rd and 6th samples; the vld gap does not break the run.
- cfg_ld len=0 -> Keff=1; i=1,0,1 with val=1 -> y=1 on the 1st and 3rd samples; det_cnt=2.
- Mid-run disturbance: after run=2 (len=3), assert cfg_ld or clr together with i=1 -> y=0, run=0; clr also zeroes det_cnt. Async rst pulse mid-run -> all outputs 0 immediately, config back to 3/1/1.
- Saturation with CNT_W=2, LEN_W=2: 10 overlapping detections -> det_cnt holds 3 and run holds 3; no wrap.
